// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared NoC definitions for the XY mesh router: flit width,
//                destination-coordinate field layout, router port identifiers
//                and the packed flit structure.
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int COORD_W    = 2;

    // Destination coordinate fields sit at the top of every flit.
    localparam int DEST_X_LSB = DATA_WIDTH - COORD_W;        // bits [31:30]
    localparam int DEST_Y_LSB = DATA_WIDTH - (2 * COORD_W);  // bits [29:28]
    localparam int PAYLOAD_W  = DATA_WIDTH - (2 * COORD_W);  // bits [27:0]

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        EAST  = 3'd3,
        WEST  = 3'd4
    } port_e;

    typedef struct packed {
        logic [COORD_W-1:0]   x;
        logic [COORD_W-1:0]   y;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;

endpackage : noc_pkg
`default_nettype wire

// File: rtl/rr_arbiter_core.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_core
//  Description : Purely combinational round-robin grant selection. Searches
//                the request vector starting one position after the last
//                winner and wrapping modulo N_PORTS.
//  Ports       : req         in  [N_PORTS-1:0]  request vector
//                last        in  [IDX_W-1:0]    index of the previous winner
//                grant       out [N_PORTS-1:0]  onehot0 grant
//                grant_idx   out [IDX_W-1:0]    index of granted requester
//                grant_valid out 1              some requester was granted
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_core
    import noc_pkg::*;
#(
    parameter int N_PORTS = 5,
    parameter int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [N_PORTS-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    // One extra bit so last + offset (at most 2*N_PORTS-1) cannot overflow
    // before the single conditional subtraction that performs the modulo.
    localparam logic [IDX_W:0] N_WIDE = (IDX_W + 1)'(N_PORTS);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        sum         = '0;
        cand        = '0;
        for (int off = 1; off <= N_PORTS; off++) begin
            sum = {1'b0, last} + (IDX_W + 1)'(off);
            if (sum >= N_WIDE) begin
                sum = sum - N_WIDE;
            end
            cand = sum[IDX_W-1:0];
            // First hit in search order wins; later hits are ignored.
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule : rr_arbiter_core
`default_nettype wire

// File: rtl/xy_output_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : xy_output_arbiter
//  Description : Output-port arbiter for an XY mesh router. Grants one of
//                N_PORTS single-flit requesters per cycle in round-robin
//                order and registers the winning flit onto the output.
//  Ports       : clk_i    in  1                       clock, rising edge
//                arstn_i  in  1                       async active-low reset
//                data_i   in  [DATA_WIDTH-1:0] x N    flit per requester
//                valid_i  in  [N_PORTS-1:0]           requester offers flit
//                ready_o  out [N_PORTS-1:0]           flit accepted this cycle
//                data_o   out [DATA_WIDTH-1:0]        registered output flit
//                valid_o  out 1                       data_o valid
//                ready_i  in  1                       downstream accepts
//  Revision    : 1.0 - initial release
// ============================================================================
module xy_output_arbiter
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = noc_pkg::DATA_WIDTH,
    parameter int N_PORTS    = 5
) (
    input  logic                  clk_i,
    input  logic                  arstn_i,
    input  logic [DATA_WIDTH-1:0] data_i [N_PORTS],
    input  logic [N_PORTS-1:0]    valid_i,
    output logic [N_PORTS-1:0]    ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    localparam int               IDX_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_PORTS - 1);

    logic [IDX_W-1:0]   last_q;
    logic [N_PORTS-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               can_load;
    logic               transfer;

    rr_arbiter_core #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_core (
        .req         (valid_i),
        .last        (last_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // The output register can take a new flit when it is empty or is being
    // drained by the downstream in this same cycle (no bubble on reload).
    assign can_load = !valid_o || ready_i;
    assign transfer = can_load && grant_valid;

    // While reset is asserted the output register reads as empty, so
    // can_load alone would still advertise readiness; qualify with the reset
    // so no requester believes its flit was taken during reset.
    assign ready_o = (can_load && arstn_i) ? grant : '0;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            last_q  <= LAST_INIT;
        end else if (transfer) begin
            data_o  <= data_i[grant_idx];
            valid_o <= 1'b1;
            last_q  <= grant_idx;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (!arstn_i)
        $onehot0(ready_o));

    a_hold_stable : assert property (@(posedge clk_i) disable iff (!arstn_i)
        (valid_o && !ready_i) |=> (valid_o && $stable(data_o)));
`endif

endmodule : xy_output_arbiter
`default_nettype wire

// File: tb/tb_xy_output_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xy_output_arbiter
//  Description : Directed self-checking bench for xy_output_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xy_output_arbiter;

    localparam int DW = 32;
    localparam int NP = 5;

    logic          clk_i;
    logic          arstn_i;
    logic [DW-1:0] data_i [NP];
    logic [NP-1:0] valid_i;
    logic [NP-1:0] ready_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;

    int errors;
    int checks;

    xy_output_arbiter #(
        .DATA_WIDTH (DW),
        .N_PORTS    (NP)
    ) dut (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Move to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        arstn_i = 1'b0;
        valid_i = '0;
        ready_i = 1'b0;
        repeat (2) next_cycle();
        arstn_i = 1'b1;
    endtask

    task automatic test_reset();
        arstn_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            valid_i = NP'($urandom_range(1, 31));
            ready_i = 1'($urandom_range(0, 1));
            for (int p = 0; p < NP; p++) data_i[p] = $urandom;
            #1;
            checks++;
            if (valid_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid: got %b want 0", valid_o);
            end
            checks++;
            if (data_o !== 32'h0) begin
                errors++;
                $display("FAIL reset_data: got %h want 00000000", data_o);
            end
            checks++;
            if (ready_o !== 5'b00000) begin
                errors++;
                $display("FAIL reset_ready: got %b want 00000", ready_o);
            end
            next_cycle();
        end
        valid_i = '0;
        ready_i = 1'b0;
        arstn_i = 1'b1;
    endtask

    task automatic test_single();
        valid_i   = 5'b00100;
        data_i[2] = 32'h11;
        ready_i   = 1'b1;
        #1;
        checks++;
        if (ready_o !== 5'b00100) begin
            errors++;
            $display("FAIL single_ready: got %b want 00100", ready_o);
        end
        next_cycle();
        valid_i = '0;
        checks++;
        if (data_o !== 32'h11 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL single_out: got data=%h valid=%b want data=00000011 valid=1",
                     data_o, valid_o);
        end
        next_cycle();
        checks++;
        if (valid_o !== 1'b0 || data_o !== 32'h11) begin
            errors++;
            $display("FAIL single_drain: got data=%h valid=%b want data=00000011 valid=0",
                     data_o, valid_o);
        end
    endtask

    task automatic test_round_robin();
        logic [NP-1:0] exp_ready;
        logic [DW-1:0] exp_data;
        do_reset();
        for (int p = 0; p < NP; p++) data_i[p] = 32'h100 + p;
        valid_i = '1;
        ready_i = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) begin
                next_cycle();
                exp_data = 32'h100 + ((k - 1) % NP);
                checks++;
                if (data_o !== exp_data || valid_o !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_out[%0d]: got data=%h valid=%b want data=%h valid=1",
                             k, data_o, valid_o, exp_data);
                end
            end
            if (k < 10) begin
                #1;
                exp_ready = NP'(1) << (k % NP);
                checks++;
                if (ready_o !== exp_ready) begin
                    errors++;
                    $display("FAIL rr_grant[%0d]: got %b want %b", k, ready_o, exp_ready);
                end
            end
        end
        valid_i = '0;
    endtask

    // Pointer sits at port 4 after the round-robin test, so port 1 leads.
    task automatic test_two_ports();
        int            sent1;
        int            sent3;
        int            exp_port;
        logic [NP-1:0] exp_ready;
        logic [DW-1:0] exp_data;
        sent1    = 0;
        sent3    = 0;
        exp_port = 1;
        ready_i  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            valid_i      = '0;
            valid_i[1]   = (sent1 < 6);
            valid_i[3]   = (sent3 < 6);
            data_i[1]    = 32'h1000 + sent1;
            data_i[3]    = 32'h3000 + sent3;
            #1;
            exp_ready = NP'(1) << exp_port;
            exp_data  = (exp_port == 1) ? 32'h1000 + sent1 : 32'h3000 + sent3;
            checks++;
            if (ready_o !== exp_ready) begin
                errors++;
                $display("FAIL two_grant[%0d]: got %b want %b", k, ready_o, exp_ready);
            end
            if (exp_port == 1) sent1++;
            else               sent3++;
            exp_port = (exp_port == 1) ? 3 : 1;
            next_cycle();
            checks++;
            if (data_o !== exp_data) begin
                errors++;
                $display("FAIL two_out[%0d]: got %h want %h", k, data_o, exp_data);
            end
        end
        valid_i = '0;
    endtask

    // Pointer sits at port 3 here; A5 comes from port 0, so port 1 is next.
    task automatic test_backpressure();
        valid_i   = 5'b00001;
        data_i[0] = 32'hA5;
        ready_i   = 1'b1;
        next_cycle();
        for (int p = 0; p < NP; p++) data_i[p] = 32'hB0 + p;
        valid_i = '1;
        ready_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (data_o !== 32'hA5 || valid_o !== 1'b1 || ready_o !== 5'b00000) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got data=%h valid=%b ready=%b want data=000000a5 valid=1 ready=00000",
                         c, data_o, valid_o, ready_o);
            end
            next_cycle();
        end
        ready_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 5'b00010) begin
            errors++;
            $display("FAIL bp_release_grant: got %b want 00010", ready_o);
        end
        next_cycle();
        valid_i = '0;
        checks++;
        if (data_o !== 32'hB1 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_out: got data=%h valid=%b want data=000000b1 valid=1",
                     data_o, valid_o);
        end
    endtask

    task automatic test_reset_mid();
        valid_i   = 5'b01000;
        data_i[3] = 32'hC3;
        ready_i   = 1'b1;
        #1;
        checks++;
        if (ready_o !== 5'b01000) begin
            errors++;
            $display("FAIL mid_grant3: got %b want 01000", ready_o);
        end
        next_cycle();
        checks++;
        if (data_o !== 32'hC3 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_loaded: got data=%h valid=%b want data=000000c3 valid=1",
                     data_o, valid_o);
        end
        for (int p = 0; p < NP; p++) data_i[p] = 32'hD0 + p;
        valid_i = '1;
        ready_i = 1'b0;
        arstn_i = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || data_o !== 32'h0 || ready_o !== 5'b00000) begin
            errors++;
            $display("FAIL mid_async: got data=%h valid=%b ready=%b want data=00000000 valid=0 ready=00000",
                     data_o, valid_o, ready_o);
        end
        repeat (2) next_cycle();
        arstn_i = 1'b1;
        ready_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 5'b00001) begin
            errors++;
            $display("FAIL mid_first_grant: got %b want 00001", ready_o);
        end
        next_cycle();
        checks++;
        if (data_o !== 32'hD0 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_first_out: got data=%h valid=%b want data=000000d0 valid=1",
                     data_o, valid_o);
        end
        valid_i = '0;
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        arstn_i = 1'b0;
        valid_i = '0;
        ready_i = 1'b0;
        for (int p = 0; p < NP; p++) data_i[p] = '0;
        next_cycle();
        test_reset();
        test_single();
        test_round_robin();
        test_two_ports();
        test_backpressure();
        test_reset_mid();
        repeat (2) next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_xy_output_arbiter
`default_nettype wire
